// File: rtl/csr_counter_timer.sv
// Machine counter/timer CSR block: mcycle, minstret, mtime, mtimecmp[NUM_CMP], mcountinhibit.
// Latency: writes visible after the write edge; reads combinational; irq registered one edge after compare.
// Backpressure: none; every CSR access completes in the cycle it is presented.
module csr_counter_timer #(
  parameter int CNT_W    = 64,
  parameter int NUM_CMP  = 2,
  parameter int PRESCALE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [11:0]        waddr_i,
  input  logic [31:0]        data_i,
  input  logic [11:0]        raddr_i,
  output logic [31:0]        data_o,
  output logic               rd_hit_o,
  input  logic               inst_retire_i,
  output logic [CNT_W-1:0]   mtime_o,
  output logic [NUM_CMP-1:0] timer_irq_o
);

  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MCNTINH   = 12'h320;
  localparam logic [11:0] A_MTIME     = 12'h7C0;
  localparam logic [11:0] A_MTIMEH    = 12'h7C1;
  localparam logic [11:0] A_MTIMECMP  = 12'h7C2;
  // With a 32-bit counter the high-half addresses still decode but hold nothing.
  localparam bit          HAS_HI      = (CNT_W > 32);
  localparam logic [15:0] PS_LAST     = 16'(PRESCALE - 1);

  logic [CNT_W-1:0]   r_mcycle;
  logic [CNT_W-1:0]   r_minstret;
  logic [CNT_W-1:0]   r_mtime;
  logic [CNT_W-1:0]   r_mtimecmp [NUM_CMP];
  logic [15:0]        r_presc;
  logic               r_inh_cy;
  logic               r_inh_ir;
  logic [NUM_CMP-1:0] r_irq;

  logic               w_wr_cyc_lo, w_wr_cyc_hi;
  logic               w_wr_ins_lo, w_wr_ins_hi;
  logic               w_wr_tim_lo, w_wr_tim_hi;
  logic               w_wr_inh;
  logic [NUM_CMP-1:0] w_wr_cmp_lo, w_wr_cmp_hi;
  logic               w_tick;

  function automatic logic [11:0] f_cmp_addr(input int idx);
    return A_MTIMECMP + 12'(2 * idx);
  endfunction

  // A half-write replaces that half only and suppresses the increment (no carry) for that edge.
  function automatic logic [CNT_W-1:0] f_next(input logic [CNT_W-1:0] cur, input logic wr_lo,
                                              input logic wr_hi, input logic inc,
                                              input logic [31:0] wdat);
    logic [63:0] t;
    t = 64'(cur);
    if (wr_lo)      t[31:0]  = wdat;
    else if (wr_hi) t[63:32] = wdat;
    else if (inc)   t        = t + 64'd1;
    return t[CNT_W-1:0];
  endfunction

  // Zero-extended 32-bit view of either half of a counter.
  function automatic logic [31:0] f_half(input logic [CNT_W-1:0] v, input logic hi);
    logic [63:0] t;
    t = 64'(v);
    return hi ? t[63:32] : t[31:0];
  endfunction

  assign w_tick      = (r_presc == PS_LAST);
  assign mtime_o     = r_mtime;
  assign timer_irq_o = r_irq;

  // Decode write strobes per register half.
  always_comb begin
    w_wr_cmp_lo = '0;
    w_wr_cmp_hi = '0;
    w_wr_cyc_lo = we_i && (waddr_i == A_MCYCLE);
    w_wr_cyc_hi = we_i && (waddr_i == A_MCYCLEH) && HAS_HI;
    w_wr_ins_lo = we_i && (waddr_i == A_MINSTRET);
    w_wr_ins_hi = we_i && (waddr_i == A_MINSTRETH) && HAS_HI;
    w_wr_tim_lo = we_i && (waddr_i == A_MTIME);
    w_wr_tim_hi = we_i && (waddr_i == A_MTIMEH) && HAS_HI;
    w_wr_inh    = we_i && (waddr_i == A_MCNTINH);
    for (int i = 0; i < NUM_CMP; i++) begin
      w_wr_cmp_lo[i] = we_i && (waddr_i == f_cmp_addr(i));
      w_wr_cmp_hi[i] = we_i && (waddr_i == f_cmp_addr(i) + 12'd1) && HAS_HI;
    end
  end

  // Counters, prescaler and inhibit bits; inhibit affects only mcycle and minstret.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
      r_mtime    <= '0;
      r_presc    <= '0;
      r_inh_cy   <= 1'b0;
      r_inh_ir   <= 1'b0;
    end else begin
      r_mcycle   <= f_next(r_mcycle, w_wr_cyc_lo, w_wr_cyc_hi, !r_inh_cy, data_i);
      r_minstret <= f_next(r_minstret, w_wr_ins_lo, w_wr_ins_hi, inst_retire_i && !r_inh_ir, data_i);
      r_mtime    <= f_next(r_mtime, w_wr_tim_lo, w_wr_tim_hi, w_tick, data_i);
      r_presc    <= w_tick ? 16'd0 : r_presc + 16'd1;
      if (w_wr_inh) begin
        r_inh_cy <= data_i[0];
        r_inh_ir <= data_i[2];
      end
    end
  end

  // Comparators and level interrupts, evaluated on pre-edge register values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CMP; i++) r_mtimecmp[i] <= '1;
      r_irq <= '0;
    end else begin
      for (int i = 0; i < NUM_CMP; i++) begin
        r_irq[i]      <= (r_mtime >= r_mtimecmp[i]);
        r_mtimecmp[i] <= f_next(r_mtimecmp[i], w_wr_cmp_lo[i], w_wr_cmp_hi[i], 1'b0, data_i);
      end
    end
  end

  // Combinational CSR read mux.
  always_comb begin
    data_o   = '0;
    rd_hit_o = 1'b0;
    case (raddr_i)
      A_MCYCLE:    begin rd_hit_o = 1'b1; data_o = f_half(r_mcycle, 1'b0);   end
      A_MCYCLEH:   begin rd_hit_o = 1'b1; data_o = f_half(r_mcycle, 1'b1);   end
      A_MINSTRET:  begin rd_hit_o = 1'b1; data_o = f_half(r_minstret, 1'b0); end
      A_MINSTRETH: begin rd_hit_o = 1'b1; data_o = f_half(r_minstret, 1'b1); end
      A_MTIME:     begin rd_hit_o = 1'b1; data_o = f_half(r_mtime, 1'b0);    end
      A_MTIMEH:    begin rd_hit_o = 1'b1; data_o = f_half(r_mtime, 1'b1);    end
      A_MCNTINH:   begin rd_hit_o = 1'b1; data_o = {29'd0, r_inh_ir, 1'b0, r_inh_cy}; end
      default:     ;
    endcase
    for (int i = 0; i < NUM_CMP; i++) begin
      if (raddr_i == f_cmp_addr(i)) begin
        rd_hit_o = 1'b1;
        data_o   = f_half(r_mtimecmp[i], 1'b0);
      end else if (raddr_i == f_cmp_addr(i) + 12'd1) begin
        rd_hit_o = 1'b1;
        data_o   = f_half(r_mtimecmp[i], 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_csr_counter_timer.sv
// Bench for csr_counter_timer: two instances (PRESCALE 1 and 4) share one stimulus stream.
// Latency: a reference model updates at each edge; outputs are checked every falling edge.
// Backpressure: not applicable; directed literal checks pin the model, then random traffic.
module tb_csr_counter_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [11:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [11:0] raddr = '0;
  logic        retire = 1'b0;

  logic [31:0] a_dat, b_dat;
  logic        a_hit, b_hit;
  logic [63:0] a_mtime, b_mtime;
  logic [1:0]  a_irq, b_irq;

  int checks = 0;
  int failures = 0;

  csr_counter_timer #(.CNT_W(64), .NUM_CMP(2), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .data_i(wdata), .raddr_i(raddr),
    .data_o(a_dat), .rd_hit_o(a_hit), .inst_retire_i(retire), .mtime_o(a_mtime),
    .timer_irq_o(a_irq));

  csr_counter_timer #(.CNT_W(64), .NUM_CMP(2), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .data_i(wdata), .raddr_i(raddr),
    .data_o(b_dat), .rd_hit_o(b_hit), .inst_retire_i(retire), .mtime_o(b_mtime),
    .timer_irq_o(b_irq));

  always #5 clk = ~clk;

  // Reference state per instance (index 0: PRESCALE=1, index 1: PRESCALE=4).
  logic [63:0] m_cyc [2];
  logic [63:0] m_ins [2];
  logic [63:0] m_time [2];
  logic [63:0] m_cmp [2][2];
  logic        m_cy [2];
  logic        m_ir [2];
  int          m_pre [2];
  logic [1:0]  m_irq [2];

  function automatic int pre_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [11:0] cmp_addr(input int i, input int hi);
    return 12'(12'h7C2 + 2 * i + hi);
  endfunction

  function automatic logic [63:0] put(input logic [63:0] v, input logic hi, input logic [31:0] x);
    return hi ? {x, v[31:0]} : {v[63:32], x};
  endfunction

  function automatic logic [32:0] model_rd(input int d, input logic [11:0] a);
    case (a)
      12'hB00: return {1'b1, m_cyc[d][31:0]};
      12'hB80: return {1'b1, m_cyc[d][63:32]};
      12'hB02: return {1'b1, m_ins[d][31:0]};
      12'hB82: return {1'b1, m_ins[d][63:32]};
      12'h7C0: return {1'b1, m_time[d][31:0]};
      12'h7C1: return {1'b1, m_time[d][63:32]};
      12'h320: return {1'b1, 29'd0, m_ir[d], 1'b0, m_cy[d]};
      default: ;
    endcase
    for (int i = 0; i < 2; i++) begin
      if (a == cmp_addr(i, 0)) return {1'b1, m_cmp[d][i][31:0]};
      if (a == cmp_addr(i, 1)) return {1'b1, m_cmp[d][i][63:32]};
    end
    return 33'd0;
  endfunction

  // Reference model: a written half replaces that half and cancels the tick; otherwise count.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        m_cyc[d] <= '0; m_ins[d] <= '0; m_time[d] <= '0; m_pre[d] <= 0;
        m_cy[d] <= 1'b0; m_ir[d] <= 1'b0; m_irq[d] <= '0;
        for (int i = 0; i < 2; i++) m_cmp[d][i] <= '1;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 2; i++) begin
          m_irq[d][i] <= (m_time[d] >= m_cmp[d][i]);
          if (we && waddr == cmp_addr(i, 0))      m_cmp[d][i] <= put(m_cmp[d][i], 1'b0, wdata);
          else if (we && waddr == cmp_addr(i, 1)) m_cmp[d][i] <= put(m_cmp[d][i], 1'b1, wdata);
        end
        m_pre[d] <= (m_pre[d] + 1) % pre_of(d);
        if (we && waddr == 12'hB00)      m_cyc[d] <= put(m_cyc[d], 1'b0, wdata);
        else if (we && waddr == 12'hB80) m_cyc[d] <= put(m_cyc[d], 1'b1, wdata);
        else if (!m_cy[d])               m_cyc[d] <= m_cyc[d] + 64'd1;
        if (we && waddr == 12'hB02)      m_ins[d] <= put(m_ins[d], 1'b0, wdata);
        else if (we && waddr == 12'hB82) m_ins[d] <= put(m_ins[d], 1'b1, wdata);
        else if (retire && !m_ir[d])     m_ins[d] <= m_ins[d] + 64'd1;
        if (we && waddr == 12'h7C0)      m_time[d] <= put(m_time[d], 1'b0, wdata);
        else if (we && waddr == 12'h7C1) m_time[d] <= put(m_time[d], 1'b1, wdata);
        else if (m_pre[d] == pre_of(d) - 1) m_time[d] <= m_time[d] + 64'd1;
        if (we && waddr == 12'h320) begin
          m_cy[d] <= wdata[0];
          m_ir[d] <= wdata[2];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge: both instances against the model.
  always @(negedge clk) begin
    chk("rd_a",    64'({a_hit, a_dat}), 64'(model_rd(0, raddr)));
    chk("mtime_a", a_mtime, m_time[0]);
    chk("irq_a",   64'(a_irq), 64'(m_irq[0]));
    chk("rd_b",    64'({b_hit, b_dat}), 64'(model_rd(1, raddr)));
    chk("mtime_b", b_mtime, m_time[1]);
    chk("irq_b",   64'(b_irq), 64'(m_irq[1]));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    we = 1'b1; waddr = a; wdata = v;
    tick(1);
    we = 1'b0;
  endtask

  task automatic rd_a(input string name, input logic [11:0] a, input logic hit, input logic [31:0] v);
    raddr = a;
    #1;
    chk(name, 64'({a_hit, a_dat}), 64'({hit, v}));
  endtask

  function automatic logic [11:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return 12'($urandom);
    case ($urandom_range(0, 13))
      0: return 12'hB00;  1: return 12'hB80;  2: return 12'hB02;  3: return 12'hB82;
      4: return 12'h320;  5: return 12'h7C0;  6: return 12'h7C1;  7: return 12'h7C2;
      8: return 12'h7C3;  9: return 12'h7C4;  10: return 12'h7C5; 11: return 12'h7C6;
      12: return 12'h123; default: return 12'hB01;
    endcase
  endfunction

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 20));
      2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    // Reset state.
    @(posedge clk); #2;
    chk("rst_mtime_a", a_mtime, 64'd0);
    chk("rst_irq_a", 64'(a_irq), 64'd0);
    rd_a("rst_cmp0_lo", 12'h7C2, 1'b1, 32'hFFFF_FFFF);
    rd_a("rst_mcycle", 12'hB00, 1'b1, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;

    // Ten edges after release with PRESCALE=1; twelve edges for PRESCALE=4.
    tick(10);
    chk("t10_mtime_a", a_mtime, 64'd10);
    chk("t10_irq_a", 64'(a_irq), 64'd0);
    rd_a("t10_mcycle", 12'hB00, 1'b1, 32'd10);
    rd_a("t10_minstret", 12'hB02, 1'b1, 32'd0);
    rd_a("t10_cmp0", 12'h7C2, 1'b1, 32'hFFFF_FFFF);
    tick(2);
    chk("t12_mtime_b", b_mtime, 64'd3);

    // mtime write, then one step per four edges on the prescaled instance.
    wr(12'h7C0, 32'd7);
    chk("wr_mtime_b", b_mtime, 64'd7);
    chk("wr_mtime_a", a_mtime, 64'd7);
    tick(4);
    chk("presc4_step1", b_mtime, 64'd8);
    tick(4);
    chk("presc4_step2", b_mtime, 64'd9);

    // Carry from low into high half; half write suppresses that edge's increment.
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'd0);
    rd_a("cyc_hold_lo", 12'hB00, 1'b1, 32'hFFFF_FFFF);
    rd_a("cyc_hold_hi", 12'hB80, 1'b1, 32'd0);
    tick(1);
    rd_a("cyc_carry_lo", 12'hB00, 1'b1, 32'd0);
    rd_a("cyc_carry_hi", 12'hB80, 1'b1, 32'd1);

    // Timer interrupt crossing and deassertion after a compare rewrite.
    wr(12'h7C2, 32'd5);
    wr(12'h7C0, 32'd0);
    wr(12'h7C3, 32'd0);
    tick(4);
    chk("cross_mtime", a_mtime, 64'd5);
    chk("cross_irq_pre", 64'(a_irq), 64'd0);
    tick(1);
    chk("cross_irq", 64'(a_irq), 64'd1);
    wr(12'h7C2, 32'd100);
    chk("rewrite_irq_hold", 64'(a_irq), 64'd1);
    tick(1);
    chk("rewrite_irq_drop", 64'(a_irq), 64'd0);
    rd_a("cmp0_lo", 12'h7C2, 1'b1, 32'd100);

    // Inhibit freezes mcycle and minstret only.
    wr(12'h320, 32'h5);
    retire = 1'b1;
    wr(12'hB00, 32'h1000);
    tick(3);
    rd_a("inh_mcycle", 12'hB00, 1'b1, 32'h1000);
    rd_a("inh_minstret", 12'hB02, 1'b1, 32'd0);
    rd_a("inh_readback", 12'h320, 1'b1, 32'h5);
    wr(12'h320, 32'h0);
    tick(2);
    retire = 1'b0;
    rd_a("resume_mcycle", 12'hB00, 1'b1, 32'h1002);
    rd_a("resume_minstret", 12'hB02, 1'b1, 32'd2);

    // Force irq high, then pulse reset between edges.
    wr(12'h7C2, 32'd0);
    tick(1);
    chk("pre_rst_irq", 64'(a_irq), 64'd1);
    raddr = 12'hB00;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_mtime_a", a_mtime, 64'd0);
    chk("async_mtime_b", b_mtime, 64'd0);
    chk("async_irq_a", 64'(a_irq), 64'd0);
    chk("async_mcycle", 64'(a_dat), 64'd0);
    rd_a("async_cmp0_hi", 12'h7C3, 1'b1, 32'hFFFF_FFFF);
    rd_a("unmapped", 12'h123, 1'b0, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      we     = ($urandom_range(0, 3) == 0);
      waddr  = pick_addr();
      wdata  = pick_data();
      raddr  = pick_addr();
      retire = ($urandom_range(0, 1) == 1);
      tick(1);
    end
    we = 1'b0;
    retire = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
